// File: rtl/apb_completer.sv
// APB completer with a DEPTH-entry register file, programmable wait states and address-range error.
// Latency: setup + WAIT_CYCLES + 1 access cycles per transfer, i.e. 2+WAIT_CYCLES cycles minimum.
// Backpressure: pready held low for WAIT_CYCLES access cycles; psel drop in ACCESS aborts the transfer.
module apb_completer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  // Register-file index width; at least one bit so a single-entry file still elaborates.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wait counter covers 0..15 wait states.
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_regs [DEPTH];

  logic              w_setup;
  logic              w_complete;
  logic              w_wr_en;
  logic              w_addr_ok;
  logic              w_pready;
  logic [IDX_W-1:0]  w_idx;

  // Full-width range check: addresses at or beyond DEPTH never alias onto a real register.
  assign w_addr_ok = (64'(r_addr) < 64'(DEPTH));
  assign w_idx     = IDX_W'(r_addr);

  // Next-state, wait-counter and transfer-event decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_setup     = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // penable without a preceding setup cycle is a protocol violation and is ignored.
        if (psel && !penable) begin
          w_setup     = 1'b1;
          w_cnt_nxt   = WAIT_INIT;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          // Master abort: drop the transfer without touching the register file.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (penable) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Only completed, in-range writes reach the register file.
  assign w_wr_en = w_complete && r_write && w_addr_ok;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the transfer attributes at setup; later bus changes during ACCESS are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else if (w_setup) begin
      r_addr  <= paddr;
      r_write <= pwrite;
      r_wdata <= pwdata;
    end
  end

  // Register file: cleared on reset, written on transfer completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[w_idx] <= r_wdata;
    end
  end

  // Response outputs decoded purely from registered state, so reset clears them immediately.
  always_comb begin
    w_pready = (r_state == ST_ACCESS) && (r_cnt == '0);
    pready   = w_pready;
    pslverr  = w_pready && !w_addr_ok;
    prdata   = '0;
    if (w_pready && !r_write && w_addr_ok) begin
      prdata = r_regs[w_idx];
    end
  end

endmodule

// File: tb/tb_apb_completer.sv
// Directed bench for apb_completer: three instances with 1, 0 and 3 wait states.
// Each step drives the bus on the falling edge and checks outputs there, away from the active edge.
// All waits are bounded; expected values are hand-computed constants.
module tb_apb_completer;

  logic       clk;
  logic       rst;
  logic       psel_a    [3];
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic       pready_a  [3];
  logic [7:0] prdata_a  [3];
  logic       pslverr_a [3];

  int checks;
  int errors;

  // Instance index: 0 -> WAIT_CYCLES=1, 1 -> WAIT_CYCLES=0, 2 -> WAIT_CYCLES=3
  apb_completer #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .psel(psel_a[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_a[0]), .prdata(prdata_a[0]),
    .pslverr(pslverr_a[0])
  );

  apb_completer #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .psel(psel_a[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_a[1]), .prdata(prdata_a[1]),
    .pslverr(pslverr_a[1])
  );

  apb_completer #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst(rst), .psel(psel_a[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready_a[2]), .prdata(prdata_a[2]),
    .pslverr(pslverr_a[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer: setup, then access until pready (bounded), scrambling the bus during waits.
  task automatic xfer(input int d, input logic wr, input logic [7:0] addr, input logic [7:0] data,
                      input int exp_wait, input logic exp_err, input logic [7:0] exp_rd,
                      input string tag);
    int n;
    @(negedge clk);
    psel_a[d] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = addr;
    pwdata    = data;
    @(negedge clk);
    penable = 1'b1;
    n = 0;
    while (pready_a[d] !== 1'b1 && n < 20) begin
      chk($sformatf("%s_wait_err", tag), {31'd0, pslverr_a[d]}, 32'd0);
      @(negedge clk);
      n++;
      paddr  = ~addr;
      pwdata = ~data;
      pwrite = ~wr;
    end
    chk($sformatf("%s_latency", tag), n, exp_wait);
    chk($sformatf("%s_pready", tag), {31'd0, pready_a[d]}, 32'd1);
    chk($sformatf("%s_pslverr", tag), {31'd0, pslverr_a[d]}, {31'd0, exp_err});
    chk($sformatf("%s_prdata", tag), {24'd0, prdata_a[d]}, {24'd0, exp_rd});
  endtask

  // Release the bus after a completed transfer; the completer must already be back in IDLE.
  task automatic idle(input int d);
    @(negedge clk);
    chk($sformatf("idle%0d_pready", d), {31'd0, pready_a[d]}, 32'd0);
    psel_a[d] = 1'b0;
    penable   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst     = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h00;
    pwdata  = 8'h00;
    for (int i = 0; i < 3; i++) psel_a[i] = 1'b0;

    // Reset state of every instance
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_pready", i), {31'd0, pready_a[i]}, 32'd0);
      chk($sformatf("rst%0d_pslverr", i), {31'd0, pslverr_a[i]}, 32'd0);
      chk($sformatf("rst%0d_prdata", i), {24'd0, prdata_a[i]}, 32'd0);
    end
    rst = 1'b1;

    // Write then read, one wait state
    xfer(0, 1'b1, 8'd3, 8'hA5, 1, 1'b0, 8'h00, "w1_wr3");
    xfer(0, 1'b0, 8'd3, 8'h00, 1, 1'b0, 8'hA5, "w1_rd3");
    idle(0);

    // Zero wait, back-to-back writes then reads
    xfer(1, 1'b1, 8'd0, 8'h11, 0, 1'b0, 8'h00, "w0_wr0");
    xfer(1, 1'b1, 8'd1, 8'h22, 0, 1'b0, 8'h00, "w0_wr1");
    xfer(1, 1'b1, 8'd2, 8'h33, 0, 1'b0, 8'h00, "w0_wr2");
    xfer(1, 1'b0, 8'd0, 8'h00, 0, 1'b0, 8'h11, "w0_rd0");
    xfer(1, 1'b0, 8'd1, 8'h00, 0, 1'b0, 8'h22, "w0_rd1");
    xfer(1, 1'b0, 8'd2, 8'h00, 0, 1'b0, 8'h33, "w0_rd2");
    idle(1);

    // Out-of-range address: error with wait states, no write, no aliasing onto reg 0
    xfer(0, 1'b1, 8'd16, 8'hFF, 1, 1'b1, 8'h00, "oor_wr16");
    xfer(0, 1'b0, 8'd16, 8'h00, 1, 1'b1, 8'h00, "oor_rd16");
    xfer(0, 1'b0, 8'd0,  8'h00, 1, 1'b0, 8'h00, "oor_rd0");
    xfer(0, 1'b0, 8'd255, 8'h00, 1, 1'b1, 8'h00, "oor_rd255");
    idle(0);

    // Master abort with three wait states
    @(negedge clk);
    psel_a[2] = 1'b1;
    penable   = 1'b0;
    pwrite    = 1'b1;
    paddr     = 8'd7;
    pwdata    = 8'h5A;
    @(negedge clk);
    penable = 1'b1;
    chk("abort_acc1_pready", {31'd0, pready_a[2]}, 32'd0);
    @(negedge clk);
    chk("abort_acc2_pready", {31'd0, pready_a[2]}, 32'd0);
    psel_a[2] = 1'b0;
    penable   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort_after%0d_pready", i), {31'd0, pready_a[2]}, 32'd0);
    end
    xfer(2, 1'b0, 8'd7, 8'h00, 3, 1'b0, 8'h00, "abort_rd7");
    idle(2);

    // Protocol violation: access phase with no setup is ignored
    @(negedge clk);
    psel_a[0] = 1'b1;
    penable   = 1'b1;
    pwrite    = 1'b1;
    paddr     = 8'd4;
    pwdata    = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("pv%0d_pready", i), {31'd0, pready_a[0]}, 32'd0);
    end
    xfer(0, 1'b0, 8'd4, 8'h00, 1, 1'b0, 8'h00, "pv_rd4_before");
    xfer(0, 1'b1, 8'd4, 8'h77, 1, 1'b0, 8'h00, "pv_wr4");
    xfer(0, 1'b0, 8'd4, 8'h00, 1, 1'b0, 8'h77, "pv_rd4_after");
    idle(0);

    // Async reset while read data is being presented: outputs drop without a clock edge
    @(negedge clk);
    psel_a[0] = 1'b1;
    penable   = 1'b0;
    pwrite    = 1'b0;
    paddr     = 8'd3;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    chk("arst_pre_pready", {31'd0, pready_a[0]}, 32'd1);
    chk("arst_pre_prdata", {24'd0, prdata_a[0]}, 32'h000000A5);
    #2 rst = 1'b0;
    #1;
    chk("arst_hi_pready", {31'd0, pready_a[0]}, 32'd0);
    chk("arst_hi_prdata", {24'd0, prdata_a[0]}, 32'd0);
    @(negedge clk);
    psel_a[0] = 1'b0;
    penable   = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Async reset in a read wait state
    xfer(0, 1'b1, 8'd5, 8'h3C, 1, 1'b0, 8'h00, "arst_wr5");
    idle(0);
    @(negedge clk);
    psel_a[0] = 1'b1;
    penable   = 1'b0;
    pwrite    = 1'b0;
    paddr     = 8'd5;
    @(negedge clk);
    penable = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("arst_wait_pready", {31'd0, pready_a[0]}, 32'd0);
    chk("arst_wait_pslverr", {31'd0, pslverr_a[0]}, 32'd0);
    chk("arst_wait_prdata", {24'd0, prdata_a[0]}, 32'd0);
    @(negedge clk);
    chk("arst_held_pready", {31'd0, pready_a[0]}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_rel_pready", {31'd0, pready_a[0]}, 32'd0);
    xfer(0, 1'b0, 8'd5, 8'h00, 1, 1'b0, 8'h00, "arst_rd5");
    xfer(0, 1'b0, 8'd3, 8'h00, 1, 1'b0, 8'h00, "arst_rd3");
    idle(0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_completer.md
Name: apb_completer

Overview:
- APB completer (slave) that answers the transfers issued by the team's APB master.
- Holds a DEPTH-entry register file of DATA_W-bit registers.
- Inserts a parameterised number of wait states via pready and flags out-of-range addresses with pslverr.
- Sits on the peripheral side of the APB link; one instance per peripheral slot.

Parameters:
- ADDR_W, 8, width of paddr.
- DATA_W, 8, width of pwdata/prdata and of each register.
- DEPTH, 16, number of registers; valid addresses 0..DEPTH-1.
- WAIT_CYCLES, 1, wait states inserted per transfer in ACCESS before pready (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- psel  input  1  completer select.
- penable  input  1  access-phase indicator.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_W  transfer address.
- pwdata  input  DATA_W  write data.
- pready  output  1  transfer completes in the cycle this is high.
- prdata  output  DATA_W  read data, valid while pready=1 and pwrite latched = 0.
- pslverr  output  1  error response, valid only while pready=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; wait counter = 0; latched addr/write/data = 0.
  - All registers cleared to 0.
  - pready=0, pslverr=0, prdata=0.
  - Reset mid-transfer aborts it; no register is written.
- States: IDLE, ACCESS.
- IDLE:
  - On the clock edge with psel=1 and penable=0 (setup phase), latch paddr, pwrite and pwdata.
  - Load wait counter with WAIT_CYCLES and go to ACCESS.
  - penable=1 seen in IDLE (protocol violation) is ignored; the block stays IDLE.
- ACCESS:
  - pready = (state==ACCESS && counter==0). It is decoded from registers only and never depends combinationally on inputs.
  - While counter != 0: decrement on each edge with psel=1.
  - On the edge with psel=1, penable=1 and counter==0, the transfer completes:
    - Write with a valid address: reg[addr] <= latched pwdata.
    - Next state is IDLE.
  - If psel=0 in ACCESS (master abort): return to IDLE, no write, pready=0.
- Latency:
  - pready rises WAIT_CYCLES cycles after the first access-phase cycle.
  - With WAIT_CYCLES=0, pready is high in the first access cycle.
  - Minimum transfer length is 2 cycles (setup + access).
- Back-to-back transfers:
  - The cycle after completion may be a new setup phase; it is accepted from IDLE with no bubble.
  - Sustained rate is one transfer per 2+WAIT_CYCLES cycles.
- Read data:
  - prdata = reg[latched addr] while pready=1 and the latched transfer is a read; otherwise 0.
  - A read and a write to the same register cannot overlap (single outstanding transfer).
- Error:
  - Latched addr >= DEPTH gives pslverr=1 together with pready.
  - The write is suppressed and prdata=0.
  - Wait states are still honoured.
  - pslverr=0 whenever pready=0.
- Address width: full ADDR_W bits are compared against DEPTH, with no aliasing or wrap. Address 16 with DEPTH=16 is an error, not reg 0.
- Mid-transfer input changes: pwdata, paddr and pwrite changes during ACCESS are ignored, because the values latched at setup are used.

Test Plan:
- Write then read, WAIT_CYCLES=1: write 0xA5 to addr 3, then read addr 3 -> pready high exactly 1 cycle after penable rises in each transfer; read returns prdata=0xA5, pslverr=0.
- Zero wait, WAIT_CYCLES=0 build: back-to-back writes to addrs 0,1,2 with data 0x11,0x22,0x33, then reads -> each transfer takes 2 cycles; readback is 0x11, 0x22, 0x33.
- Out-of-range: write 0xFF to addr 16, then read addr 16 and addr 0 (previously 0x00) -> pslverr=1 with pready on both addr-16 accesses; prdata=0; reg 0 still 0x00.
- Abort: with WAIT_CYCLES=3, write 0x5A to addr 7 and drop psel after 1 access cycle; then read addr 7 -> pready never asserted for the write; read returns 0x00.
- Async reset: write 0x3C to addr 5; assert rst=0 mid-way through a later read wait state, off a clock edge -> pready/pslverr/prdata drop to 0 immediately; after release, read addr 5 returns 0x00.
- Protocol violation: drive psel=1, penable=1 with no setup cycle -> no pready, no register change; a following proper setup/access completes normally.
